// File: rtl/nv_nvdla_sdp_mrdma_eg_sfifo_ctrl_pkg.sv
// Shared constants for the SDP MRDMA egress skid FIFO and its flop RAM.
// The payload width and default depth are fixed by the egress datapath.
package nv_nvdla_sdp_mrdma_eg_sfifo_ctrl_pkg;

   localparam int SDP_MRDMA_EG_PD_W          = 256;
   localparam int SDP_MRDMA_EG_SFIFO_DEPTH   = 4;
   localparam int SDP_MRDMA_EG_PWRBUS_W      = 32;

   // Occupancy update selector: {push, pop}.
   typedef enum logic [1:0] {
      CNT_HOLD_IDLE = 2'b00,
      CNT_DEC       = 2'b01,
      CNT_INC       = 2'b10,
      CNT_HOLD_BOTH = 2'b11
   } cnt_op_e;

   function automatic cnt_op_e cnt_op(input logic push, input logic pop);
      return cnt_op_e'({push, pop});
   endfunction

endpackage

// File: rtl/nv_nvdla_sdp_mrdma_eg_sfifo_flopram_rwsa_4x256.sv
// Flop-based storage for the egress FIFO: one synchronous write port and an
// asynchronous read port with no write-to-read bypass. Contents are not reset.
module nv_nvdla_sdp_mrdma_eg_sfifo_flopram_rwsa_4x256
   import nv_nvdla_sdp_mrdma_eg_sfifo_ctrl_pkg::*;
#(
   parameter  int DEPTH = SDP_MRDMA_EG_SFIFO_DEPTH,
   parameter  int WIDTH = SDP_MRDMA_EG_PD_W,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                             clk,
   input  logic [SDP_MRDMA_EG_PWRBUS_W-1:0] pwrbus_ram_pd,
   input  logic                             we,
   input  logic [AW-1:0]                    wa,
   input  logic [WIDTH-1:0]                 di,
   input  logic [AW-1:0]                    ra,
   output logic [WIDTH-1:0]                 dout
);

   logic [WIDTH-1:0] ram [DEPTH];

   // Power-down bus has no functional effect on flop storage.
   logic pwrbus_unused;
   assign pwrbus_unused = ^pwrbus_ram_pd;

   always_ff @(posedge clk) begin
      if (we) begin
         ram[wa] <= di;
      end
   end

   assign dout = ram[ra];

endmodule

// File: rtl/nv_nvdla_sdp_mrdma_eg_sfifo_ctrl.sv
// Valid/ready FIFO controller for the SDP MRDMA egress path: owns pointers,
// occupancy and both handshakes, and drives the flop RAM write/read ports.
module nv_nvdla_sdp_mrdma_eg_sfifo_ctrl
   import nv_nvdla_sdp_mrdma_eg_sfifo_ctrl_pkg::*;
#(
   parameter  int DEPTH = SDP_MRDMA_EG_SFIFO_DEPTH,
   parameter  int WIDTH = SDP_MRDMA_EG_PD_W,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [SDP_MRDMA_EG_PWRBUS_W-1:0] pwrbus_ram_pd,
   input  logic                             wr_pvld,
   output logic                             wr_prdy,
   input  logic [WIDTH-1:0]                 wr_pd,
   output logic                             rd_pvld,
   input  logic                             rd_prdy,
   output logic [WIDTH-1:0]                 rd_pd,
   output logic [AW:0]                      wr_count
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] rd_ptr_next;
   logic [AW:0]   count_reg;
   logic [AW:0]   count_next;
   logic          push;
   logic          pop;

   // Both ready/valid depend on registered count only, so no rd_prdy->wr_prdy path.
   assign wr_prdy  = (count_reg != FULL_COUNT);
   assign rd_pvld  = (count_reg != '0);
   assign wr_count = count_reg;

   assign push = wr_pvld & wr_prdy;
   assign pop  = rd_pvld & rd_prdy;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;

      // DEPTH is a power of two, so the AW-bit increment wraps naturally.
      if (push) begin
         wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + 1'b1;
      end

      case (cnt_op(push, pop))
         CNT_INC:       count_next = count_reg + 1'b1;
         CNT_DEC:       count_next = count_reg - 1'b1;
         CNT_HOLD_IDLE: count_next = count_reg;
         CNT_HOLD_BOTH: count_next = count_reg;
         default:       count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   nv_nvdla_sdp_mrdma_eg_sfifo_flopram_rwsa_4x256 #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_ram (
      .clk           (clk),
      .pwrbus_ram_pd (pwrbus_ram_pd),
      .we            (push),
      .wa            (wr_ptr_reg),
      .di            (wr_pd),
      .ra            (rd_ptr_reg),
      .dout          (rd_pd)
   );

endmodule

// File: tb/tb_nv_nvdla_sdp_mrdma_eg_sfifo_ctrl.sv
// Self-checking bench: constant vector table, hand sequences and a randomized
// run against a queue-based FIFO model.
module tb_nv_nvdla_sdp_mrdma_eg_sfifo_ctrl;

   localparam int DEPTH = 4;
   localparam int W     = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   pwrbus_ram_pd;
   logic          wr_pvld;
   logic          wr_prdy;
   logic [W-1:0]  wr_pd;
   logic          rd_pvld;
   logic          rd_prdy;
   logic [W-1:0]  rd_pd;
   logic [2:0]    wr_count;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] model_q[$];
   logic         prev_stall;
   logic [W-1:0] prev_pd;

   always #5 clk = ~clk;

   nv_nvdla_sdp_mrdma_eg_sfifo_ctrl #(
      .DEPTH (DEPTH),
      .WIDTH (W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pwrbus_ram_pd (pwrbus_ram_pd),
      .wr_pvld       (wr_pvld),
      .wr_prdy       (wr_prdy),
      .wr_pd         (wr_pd),
      .rd_pvld       (rd_pvld),
      .rd_prdy       (rd_prdy),
      .rd_pd         (rd_pd),
      .wr_count      (wr_count)
   );

   typedef struct {
      logic         wv;
      logic         rr;
      logic [W-1:0] d;
      logic         e_prdy;
      logic         e_pvld;
      logic [2:0]   e_cnt;
      logic         chk_pd;
      logic [W-1:0] e_pd;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wv, input logic rr, input logic [W-1:0] d,
                               input logic ep, input logic ev, input logic [2:0] ec,
                               input logic cp, input logic [W-1:0] epd);
      vec_t v;
      v.wv = wv; v.rr = rr; v.d = d;
      v.e_prdy = ep; v.e_pvld = ev; v.e_cnt = ec; v.chk_pd = cp; v.e_pd = epd;
      return v;
   endfunction

   // One cycle: drive, compare against the queue model, then advance it.
   task automatic step(input logic wv, input logic rr, input logic [W-1:0] d);
      logic do_push;
      logic do_pop;
      @(negedge clk);
      wr_pvld = wv; rd_prdy = rr; wr_pd = d;
      #1;
      chk("wr_prdy", W'(wr_prdy), W'(model_q.size() < DEPTH));
      chk("rd_pvld", W'(rd_pvld), W'(model_q.size() > 0));
      chk("wr_count", W'(wr_count), W'(model_q.size()));
      chk("count_bound", W'(wr_count <= 3'(DEPTH)), W'(1));
      if (model_q.size() > 0) chk("rd_pd", rd_pd, model_q[0]);
      if (prev_stall) chk("rd_pd_stable", rd_pd, prev_pd);
      prev_stall = rd_pvld && !rr;
      prev_pd    = rd_pd;
      do_push = wv && (model_q.size() < DEPTH);
      do_pop  = rr && (model_q.size() > 0);
      @(posedge clk);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
   endtask

   initial begin
      logic [W-1:0] a5;
      a5 = {32{8'hA5}};
      rst = 1'b1; pwrbus_ram_pd = 32'h0;
      wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
      prev_stall = 1'b0; prev_pd = '0;

      // Reset values while reset is held.
      #2;
      chk("rst_wr_prdy", W'(wr_prdy), W'(1));
      chk("rst_rd_pvld", W'(rd_pvld), W'(0));
      chk("rst_wr_count", W'(wr_count), W'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Idle, single beat, fill to full, blocked push at full, push+pop at count 2.
      vecs[0]  = mk(0, 0, '0,    1, 0, 0, 0, '0);
      vecs[1]  = mk(1, 0, a5,    1, 0, 0, 0, '0);
      vecs[2]  = mk(0, 0, '0,    1, 1, 1, 1, a5);
      vecs[3]  = mk(0, 1, '0,    1, 1, 1, 1, a5);
      vecs[4]  = mk(0, 0, '0,    1, 0, 0, 0, '0);
      vecs[5]  = mk(1, 0, W'(1), 1, 0, 0, 0, '0);
      vecs[6]  = mk(1, 0, W'(2), 1, 1, 1, 1, W'(1));
      vecs[7]  = mk(1, 0, W'(3), 1, 1, 2, 1, W'(1));
      vecs[8]  = mk(1, 0, W'(4), 1, 1, 3, 1, W'(1));
      vecs[9]  = mk(1, 0, W'(5), 0, 1, 4, 1, W'(1));
      vecs[10] = mk(1, 0, W'(5), 0, 1, 4, 1, W'(1));
      vecs[11] = mk(1, 1, W'(5), 0, 1, 4, 1, W'(1));
      vecs[12] = mk(0, 0, '0,    1, 1, 3, 1, W'(2));
      vecs[13] = mk(0, 1, '0,    1, 1, 3, 1, W'(2));
      vecs[14] = mk(1, 1, W'(6), 1, 1, 2, 1, W'(3));
      vecs[15] = mk(0, 0, '0,    1, 1, 2, 1, W'(4));
      vecs[16] = mk(0, 1, '0,    1, 1, 2, 1, W'(4));
      vecs[17] = mk(0, 1, '0,    1, 1, 1, 1, W'(6));
      vecs[18] = mk(0, 0, '0,    1, 0, 0, 0, '0);

      for (int i = 0; i < 19; i++) begin
         int f0;
         f0 = failures;
         @(negedge clk);
         wr_pvld = vecs[i].wv; rd_prdy = vecs[i].rr; wr_pd = vecs[i].d;
         #1;
         chk("vec_wr_prdy", W'(wr_prdy), W'(vecs[i].e_prdy));
         chk("vec_rd_pvld", W'(rd_pvld), W'(vecs[i].e_pvld));
         chk("vec_wr_count", W'(wr_count), W'(vecs[i].e_cnt));
         if (vecs[i].chk_pd) chk("vec_rd_pd", rd_pd, vecs[i].e_pd);
         $display("vec %0d wv=%0b rr=%0b cnt=%0d errs=%0d", i, vecs[i].wv, vecs[i].rr,
                  wr_count, failures - f0);
      end

      // Asynchronous reset mid-stream with three beats held.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(100 + i));
      @(negedge clk);
      wr_pvld = 1'b0; rd_prdy = 1'b0;
      chk("pre_rst_count", W'(wr_count), W'(3));
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count", W'(wr_count), W'(0));
      chk("async_rst_rd_pvld", W'(rd_pvld), W'(0));
      chk("async_rst_wr_prdy", W'(wr_prdy), W'(1));
      @(negedge clk);
      rst = 1'b0;
      model_q.delete();
      prev_stall = 1'b0;
      $display("seq mid_reset done");

      // Streaming at count 1 for 20 beats; pointers wrap five times.
      step(1'b1, 1'b0, W'(0));
      for (int i = 1; i < 20; i++) begin
         step(1'b1, 1'b1, W'(i));
         chk("stream_count", W'(wr_count), W'(1));
         chk("stream_pd", rd_pd, W'(i - 1));
      end
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
      $display("seq stream done");

      // Simultaneous push and pop at full is blocked on the push side.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, W'(200 + i));
      step(1'b1, 1'b1, W'(299));
      step(1'b0, 1'b0, '0);
      chk("full_both_count", W'(wr_count), W'(3));
      while (model_q.size() > 0) step(1'b0, 1'b1, '0);
      $display("seq full_both done");

      // Random traffic against the model.
      for (int c = 0; c < 10000; c++) begin
         logic [W-1:0] d;
         for (int k = 0; k < W / 32; k++) d[k*32 +: 32] = $urandom();
         step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 55), d);
      end
      while (model_q.size() > 0) step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
      chk("final_count", W'(wr_count), W'(0));
      $display("seq random done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
